// File: rtl/checkbits_latency_monitor.sv
// Times FIR runs bracketed by start/end markers on the checkbits bus and queues
// per-run results {idx, y, cycles} in a small valid/ready FIFO.
module checkbits_latency_monitor #(
  parameter logic [15:0] START_MARK  = 16'h00A5,
  parameter logic [7:0]  END_MARK    = 8'h5A,
  parameter int          NUM_RUNS    = 3,
  parameter int          CYC_W       = 32,
  parameter int          TIMEOUT_CYC = 250000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic             clock,
  input  logic             RSTB,
  input  logic [15:0]      checkbits,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_idx,
  output logic [7:0]       res_y,
  output logic [CYC_W-1:0] res_cycles,
  output logic [CYC_W-1:0] total_cycles,
  output logic [7:0]       runs_done,
  output logic             busy,
  output logic             all_done,
  output logic             timeout,
  output logic             overflow
);

  // state  | meaning
  // ARMED  | waiting for the full 16-bit start marker
  // TIMING | run in flight, counting edges until the end marker
  // DONE   | NUM_RUNS completed or timed out; checkbits ignored
  typedef enum logic [1:0] {ARMED, TIMING, DONE} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] RUNS_LAST = 8'(NUM_RUNS - 1);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_t state, state_nxt;
  logic [CYC_W-1:0] run_cnt, run_nxt;
  logic [TO_W-1:0]  glob_cnt;
  logic             push, set_all_done, set_timeout;
  logic             start_hit, end_hit, tmo_hit;
  logic [CYC_W:0]   total_sum;
  logic [CYC_W-1:0] total_nxt;

  logic [7:0]       mem_idx [FIFO_DEPTH];
  logic [7:0]       mem_y   [FIFO_DEPTH];
  logic [CYC_W-1:0] mem_cyc [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full, pop, do_push;

  assign start_hit = (checkbits == START_MARK);
  assign end_hit   = (checkbits[7:0] == END_MARK);
  assign tmo_hit   = (state != DONE) && (glob_cnt == TO_LAST);

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) state <= ARMED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    run_nxt      = run_cnt;
    push         = 1'b0;
    set_all_done = 1'b0;
    set_timeout  = 1'b0;
    case (state)
      ARMED: begin
        if (start_hit) begin
          state_nxt = TIMING;
          run_nxt   = CYC_W'(1);
        end
      end
      TIMING: begin
        if (end_hit) begin
          push = 1'b1;
          if (runs_done == RUNS_LAST) begin
            state_nxt    = DONE;
            set_all_done = 1'b1;
          end else begin
            state_nxt = ARMED;
          end
        end else if (run_cnt != CYC_MAX) begin
          run_nxt = run_cnt + CYC_W'(1);
        end
      end
      default: ;
    endcase
    // A run completing on the timeout edge is kept; the timeout only wins if
    // that completion did not also finish the whole sequence.
    if (tmo_hit && !set_all_done) begin
      set_timeout = 1'b1;
      state_nxt   = DONE;
    end
  end

  assign total_sum = {1'b0, total_cycles} + {1'b0, run_cnt};
  assign total_nxt = total_sum[CYC_W] ? CYC_MAX : total_sum[CYC_W-1:0];

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      run_cnt      <= '0;
      glob_cnt     <= '0;
      total_cycles <= '0;
      runs_done    <= '0;
      all_done     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      run_cnt <= run_nxt;
      if (state != DONE) glob_cnt <= glob_cnt + TO_W'(1);
      if (push) begin
        total_cycles <= total_nxt;
        runs_done    <= runs_done + 8'd1;
      end
      if (set_all_done) all_done <= 1'b1;
      if (set_timeout)  timeout  <= 1'b1;
    end
  end

  assign busy = (state == TIMING);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && res_ready;
  assign do_push    = push && (!fifo_full || pop);

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_idx[wr_ptr[AW-1:0]] <= runs_done;
      mem_y[wr_ptr[AW-1:0]]   <= checkbits[15:8];
      mem_cyc[wr_ptr[AW-1:0]] <= run_cnt;
    end
  end

  assign res_valid  = !fifo_empty;
  assign res_idx    = res_valid ? mem_idx[rd_ptr[AW-1:0]] : '0;
  assign res_y      = res_valid ? mem_y[rd_ptr[AW-1:0]]   : '0;
  assign res_cycles = res_valid ? mem_cyc[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_checkbits_latency_monitor.sv
// Bench for checkbits_latency_monitor: directed scenarios plus randomized runs
// compared against a timestamp/queue reference model.
module tb_checkbits_latency_monitor;

  localparam int TO    = 500;
  localparam int DEPTH = 2;
  localparam int NRUNS = 3;

  logic        clock = 1'b0;
  logic        RSTB  = 1'b0;
  logic [15:0] checkbits = '0;
  logic        res_ready = 1'b0;
  logic        res_valid, busy, all_done, timeout, overflow;
  logic [7:0]  res_idx, res_y, runs_done;
  logic [31:0] res_cycles, total_cycles;

  checkbits_latency_monitor #(
    .TIMEOUT_CYC(TO),
    .FIFO_DEPTH(DEPTH),
    .NUM_RUNS(NRUNS)
  ) dut (
    .clock(clock), .RSTB(RSTB), .checkbits(checkbits),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_y(res_y), .res_cycles(res_cycles), .total_cycles(total_cycles),
    .runs_done(runs_done), .busy(busy), .all_done(all_done),
    .timeout(timeout), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference model: edge timestamps and a bounded result queue
  typedef struct { int idx; int y; int cyc; } ent_t;
  ent_t q[$];
  int   m_edge, m_tstart, m_runs;
  longint m_total;
  bit   m_timing, m_done, m_all_done, m_timeout, m_overflow;

  function automatic void model_reset();
    q.delete();
    m_edge = 0; m_tstart = 0; m_runs = 0; m_total = 0;
    m_timing = 0; m_done = 0; m_all_done = 0; m_timeout = 0; m_overflow = 0;
  endfunction

  function automatic void model_edge(input logic [15:0] cb, input bit popped);
    ent_t e;
    if (popped) void'(q.pop_front());
    if (!m_done) begin
      m_edge++;
      if (!m_timing) begin
        if (cb == 16'h00A5) begin m_timing = 1; m_tstart = m_edge; end
      end else if (cb[7:0] == 8'h5A) begin
        e.idx = m_runs; e.y = int'(cb[15:8]); e.cyc = m_edge - m_tstart;
        if (q.size() == DEPTH) m_overflow = 1;
        else q.push_back(e);
        m_total += e.cyc;
        m_runs++;
        m_timing = 0;
        if (m_runs == NRUNS) begin m_done = 1; m_all_done = 1; end
      end
      if (!m_done && m_edge == TO) begin m_timeout = 1; m_done = 1; m_timing = 0; end
    end
  endfunction

  task automatic check_status();
    chk("res_valid", res_valid, q.size() != 0);
    chk("busy", busy, m_timing);
    chk("runs_done", runs_done, m_runs);
    chk("total_cycles", total_cycles, m_total[31:0]);
    chk("all_done", all_done, m_all_done);
    chk("timeout", timeout, m_timeout);
    chk("overflow", overflow, m_overflow);
  endtask

  task automatic step(input logic [15:0] cb, input bit rdy);
    bit popped;
    checkbits = cb;
    res_ready = rdy;
    popped = rdy && (q.size() != 0);
    if (popped) begin
      chk("head_idx", res_idx, q[0].idx);
      chk("head_y", res_y, q[0].y);
      chk("head_cycles", res_cycles, q[0].cyc);
    end
    @(posedge clock); #1;
    model_edge(cb, popped);
    check_status();
  endtask

  function automatic logic [15:0] filler();
    logic [15:0] v;
    v = 16'($urandom);
    if (v[7:0] == 8'h5A) v[7:0] = 8'h3C;
    if (v == 16'h00A5) v = 16'h00A4;
    return v;
  endfunction

  function automatic bit pick_rdy(input int mode);
    if (mode == 2) return bit'($urandom_range(0, 1));
    return bit'(mode);
  endfunction

  // gap idle edges, start edge, len-1 filler edges, end edge: latency = len
  task automatic do_run(input int gap, input int len, input logic [7:0] y,
                        input int rdy_mode, input bit inject);
    logic [15:0] v;
    for (int i = 0; i < gap; i++) begin
      v = (inject && $urandom_range(0, 3) == 0) ? 16'h005A : filler();
      step(v, pick_rdy(rdy_mode));
    end
    step(16'h00A5, pick_rdy(rdy_mode));
    for (int i = 1; i < len; i++) begin
      v = (inject && $urandom_range(0, 7) == 0) ? 16'h00A5 : filler();
      step(v, pick_rdy(rdy_mode));
    end
    step({y, 8'h5A}, pick_rdy(rdy_mode));
  endtask

  task automatic do_reset();
    RSTB = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_runs_done", runs_done, 8'd0);
    chk("rst_total", total_cycles, 32'd0);
    chk("rst_flags", {all_done, timeout, overflow}, 3'b000);
    model_reset();
    @(posedge clock); #1;
    RSTB = 1'b1;
  endtask

  int pops;

  initial begin
    model_reset();
    #2;
    do_reset();

    // single run: start at edge 10, end 0x2D5A at edge 110
    do_run(9, 100, 8'h2D, 0, 0);
    chk("t1_valid", res_valid, 1'b1);
    chk("t1_idx", res_idx, 8'd0);
    chk("t1_y", res_y, 8'h2D);
    chk("t1_cycles", res_cycles, 32'd100);

    // three runs, always ready, then a further start marker is ignored
    do_reset();
    do_run(1, 100, 8'h10, 1, 0);
    do_run(0, 250, 8'h20, 1, 0);
    do_run(0, 37, 8'h30, 1, 0);
    chk("t2_total", total_cycles, 32'd387);
    chk("t2_all_done", all_done, 1'b1);
    step(16'h00A5, 1'b1);
    for (int i = 0; i < 3; i++) step(filler(), 1'b1);
    chk("t2_busy_after", busy, 1'b0);

    // no consumer: third result dropped
    do_reset();
    do_run(2, 20, 8'hA1, 0, 0);
    do_run(2, 30, 8'hA2, 0, 0);
    do_run(2, 40, 8'hA3, 0, 0);
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_runs", runs_done, 8'd3);
    chk("t3_total", total_cycles, 32'd90);
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid) pops++;
      step(filler(), 1'b1);
    end
    chk("t3_drain_cnt", pops, 2);

    // start held forever, never an end marker
    do_reset();
    for (int i = 0; i < TO + 5; i++) step(16'h00A5, 1'b0);
    chk("t4_timeout", timeout, 1'b1);
    chk("t4_all_done", all_done, 1'b0);
    chk("t4_valid", res_valid, 1'b0);

    // stray markers have no effect
    do_reset();
    step(16'h005A, 1'b0);
    step(16'h005A, 1'b0);
    step(16'h00A5, 1'b0);
    for (int i = 0; i < 10; i++) step(filler(), 1'b0);
    step(16'h00A5, 1'b0);
    for (int i = 0; i < 5; i++) step(filler(), 1'b0);
    step(16'h00A5, 1'b0);
    step(16'h775A, 1'b0);
    chk("t5_cycles", res_cycles, 32'd18);
    chk("t5_y", res_y, 8'h77);

    // end marker on the timeout edge
    do_reset();
    do_run(0, TO - 1, 8'h44, 0, 0);
    chk("t6_timeout", timeout, 1'b1);
    chk("t6_valid", res_valid, 1'b1);
    chk("t6_cycles", res_cycles, 32'(TO - 1));
    chk("t6_runs", runs_done, 8'd1);

    // reset in the middle of a run with an entry queued
    do_reset();
    do_run(2, 30, 8'h11, 0, 0);
    step(16'h00A5, 1'b0);
    for (int i = 0; i < 7; i++) step(filler(), 1'b0);
    #2;
    do_reset();
    do_run(3, 40, 8'h22, 0, 0);
    chk("t7_idx", res_idx, 8'd0);
    chk("t7_cycles", res_cycles, 32'd40);

    // randomized runs with random consumer and stray markers
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int k = 0; k < 4; k++)
        do_run($urandom_range(0, 5), $urandom_range(1, 200), 8'($urandom), 2, 1);
      for (int i = 0; i < 4; i++) step(filler(), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
